// File: rtl/module_keypad_scan_n_if.sv
// Keypad pin and key-event bundle between the scanner (master) and its
// environment (slave: keypad pins on one side, key consumer on the other).
interface module_keypad_scan_n_if #(
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4
);
  localparam int CODE_W = $clog2(N_ROWS * N_COLS);

  logic [N_ROWS-1:0] row;
  logic [N_COLS-1:0] column;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_held;

  modport master (input row, output column, output key_code, output key_valid, output key_held);
  modport slave  (output row, input column, input key_code, input key_valid, input key_held);
endinterface

// File: rtl/module_keypad_scan_n.sv
// Matrix keypad scanner: walks an active-low column strobe, debounces the first
// low row found, and reports a linear key code with optional auto-repeat.
module module_keypad_scan_n #(
  parameter int N_ROWS       = 4,
  parameter int N_COLS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_TICKS = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  module_keypad_scan_n_if.master kp
);

  localparam int CODE_W = $clog2(N_ROWS * N_COLS);
  localparam int COL_W  = $clog2(N_COLS);
  localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam int REP_W  = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;

  localparam logic [1:0] ST_SCAN = 2'd0;
  localparam logic [1:0] ST_DEB  = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;
  localparam logic [1:0] ST_REL  = 2'd3;

  logic [N_ROWS-1:0] row_meta_q, row_meta_d;
  logic [N_ROWS-1:0] rs_q, rs_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [1:0]        state_q, state_d;
  logic [COL_W-1:0]  col_idx_q, col_idx_d;
  logic [ROW_W-1:0]  r_idx_q, r_idx_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;

  logic              tick;
  logic              any_low;
  logic              rs_sel;
  logic              accept;
  logic [ROW_W-1:0]  low_idx;
  logic [COL_W-1:0]  col_next;

  always_comb begin
    row_meta_d = kp.row;
    rs_d       = row_meta_q;
    tick       = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    col_next   = (col_idx_q == COL_W'(N_COLS - 1)) ? '0 : col_idx_q + 1'b1;
    any_low    = ~&rs_q;
    rs_sel     = rs_q[r_idx_q];

    // Descending walk so the lowest low row is the one left standing.
    low_idx = '0;
    for (int i = N_ROWS - 1; i >= 0; i--) begin
      if (!rs_q[i]) low_idx = ROW_W'(i);
    end

    state_d     = state_q;
    col_idx_d   = col_idx_q;
    r_idx_d     = r_idx_q;
    deb_cnt_d   = deb_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    accept      = 1'b0;

    case (state_q)
      ST_SCAN: begin
        if (tick) begin
          if (!any_low) begin
            col_idx_d = col_next;
          end else begin
            r_idx_d   = low_idx;
            deb_cnt_d = DEB_W'(1);
            if (DEBOUNCE_CNT == 1) begin
              accept    = 1'b1;
              rep_cnt_d = '0;
              state_d   = ST_HELD;
            end else begin
              state_d = ST_DEB;
            end
          end
        end
      end
      ST_DEB: begin
        if (tick) begin
          if (!rs_sel) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
            if (deb_cnt_q == DEB_W'(DEBOUNCE_CNT - 1)) begin
              accept    = 1'b1;
              rep_cnt_d = '0;
              state_d   = ST_HELD;
            end
          end else begin
            col_idx_d = col_next;
            state_d   = ST_SCAN;
          end
        end
      end
      ST_HELD: begin
        if (tick) begin
          if (rs_sel) begin
            deb_cnt_d = DEB_W'(1);
            if (DEBOUNCE_CNT == 1) begin
              col_idx_d = col_next;
              state_d   = ST_SCAN;
            end else begin
              state_d = ST_REL;
            end
          end else if (REPEAT_TICKS > 0) begin
            if (rep_cnt_q == REP_W'(REPEAT_TICKS - 1)) begin
              key_valid_d = 1'b1;
              rep_cnt_d   = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
        end
      end
      default: begin
        if (tick) begin
          if (rs_sel) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
            if (deb_cnt_q == DEB_W'(DEBOUNCE_CNT - 1)) begin
              col_idx_d = col_next;
              state_d   = ST_SCAN;
            end
          end else begin
            rep_cnt_d = '0;
            state_d   = ST_HELD;
          end
        end
      end
    endcase

    // r_idx_d already carries the row being accepted in every accepting path.
    if (accept) begin
      key_code_d  = CODE_W'(r_idx_d) * CODE_W'(N_COLS) + CODE_W'(col_idx_q);
      key_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q  <= '1;
      rs_q        <= '1;
      div_cnt_q   <= '0;
      state_q     <= ST_SCAN;
      col_idx_q   <= '0;
      r_idx_q     <= '0;
      deb_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      row_meta_q  <= row_meta_d;
      rs_q        <= rs_d;
      div_cnt_q   <= div_cnt_d;
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      r_idx_q     <= r_idx_d;
      deb_cnt_q   <= deb_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign kp.column    = ~(N_COLS'(1) << col_idx_q);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = (state_q == ST_HELD);

endmodule

// File: tb/tb_module_keypad_scan_n.sv
// Directed bench for module_keypad_scan_n with a 4x4 keypad model; a second
// instance with auto-repeat enabled covers the repeat cadence.
module tb_module_keypad_scan_n;

  logic        clk;
  logic        rst;
  logic [15:0] keys;
  logic [15:0] rkeys;
  logic [3:0]  exp_col;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          strobes  = 0;
  int          last_code = 0;
  int          cyc      = 0;
  int          s0;
  int          t_prev;

  module_keypad_scan_n_if #(.N_ROWS(4), .N_COLS(4)) kif ();
  module_keypad_scan_n_if #(.N_ROWS(4), .N_COLS(4)) rkif ();

  module_keypad_scan_n #(
    .N_ROWS(4), .N_COLS(4), .SCAN_DIV(4), .DEBOUNCE_CNT(3), .REPEAT_TICKS(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kif)
  );

  module_keypad_scan_n #(
    .N_ROWS(4), .N_COLS(4), .SCAN_DIV(4), .DEBOUNCE_CNT(3), .REPEAT_TICKS(8)
  ) dut_rep (
    .clk(clk),
    .rst(rst),
    .kp (rkif)
  );

  // Row r is pulled low when key (r,c) is pressed and column c is driven low.
  function automatic logic [3:0] pad(input logic [15:0] k, input logic [3:0] col);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (k[ri*4+ci] && !col[ci]) r[ri] = 1'b0;
    return r;
  endfunction

  assign kif.row  = pad(keys, kif.column);
  assign rkif.row = pad(rkeys, rkif.column);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (kif.key_valid === 1'b1) begin
      strobes   <= strobes + 1;
      last_code <= int'(kif.key_code);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_col(input logic [3:0] target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(posedge clk);
      #1;
      if (kif.column === target) found = 1'b1;
    end
    check("wait_col", 32'(kif.column), 32'(target));
  endtask

  task automatic wait_rep_valid();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #1;
      if (rkif.key_valid === 1'b1) found = 1'b1;
    end
    check("rep_strobe_seen", 32'(found), 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    keys  = '0;
    rkeys = '0;

    // 1: reset values, then idle column walk
    wait_clk(10);
    check("rst_column", 32'(kif.column), 32'(4'b1110));
    check("rst_key_valid", 32'(kif.key_valid), 32'd0);
    check("rst_key_code", 32'(kif.key_code), 32'd0);
    check("rst_key_held", 32'(kif.key_held), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      wait_clk(1);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("idle_column", 32'(kif.column), 32'(exp_col));
    end
    check("idle_no_strobe", 32'(strobes), 32'd0);

    // 2: single press of (0,0)
    s0 = strobes;
    keys[0] = 1'b1;
    wait_clk(100);
    check("k00_strobes", 32'(strobes - s0), 32'd1);
    check("k00_code", 32'(last_code), 32'd0);
    check("k00_held", 32'(kif.key_held), 32'd1);
    keys = '0;
    wait_clk(1);
    check("k00_held_during_release", 32'(kif.key_held), 32'd1);
    wait_clk(40);
    check("k00_released", 32'(kif.key_held), 32'd0);
    check("k00_one_strobe", 32'(strobes - s0), 32'd1);

    // 3: (2,1) then (3,3)
    s0 = strobes;
    keys[2*4+1] = 1'b1;
    wait_clk(100);
    check("k21_strobes", 32'(strobes - s0), 32'd1);
    check("k21_code", 32'(last_code), 32'd9);
    keys = '0;
    wait_clk(40);
    s0 = strobes;
    keys[3*4+3] = 1'b1;
    wait_clk(100);
    check("k33_strobes", 32'(strobes - s0), 32'd1);
    check("k33_code", 32'(kif.key_code), 32'd15);
    keys = '0;
    wait_clk(40);
    check("k33_key_code_holds", 32'(kif.key_code), 32'd15);

    // 4: (1,2) low for exactly one sample, then stable
    wait_col(4'b1110);
    wait_col(4'b1011);
    s0 = strobes;
    keys[1*4+2] = 1'b1;
    wait_clk(3);
    keys = '0;
    wait_clk(5);
    check("bounce_abandon_column", 32'(kif.column), 32'(4'b0111));
    check("bounce_no_strobe", 32'(strobes - s0), 32'd0);
    check("bounce_not_held", 32'(kif.key_held), 32'd0);
    keys[1*4+2] = 1'b1;
    wait_clk(100);
    check("k12_strobes", 32'(strobes - s0), 32'd1);
    check("k12_code", 32'(last_code), 32'd6);
    keys = '0;
    wait_clk(40);

    // 5: auto-repeat instance, hold (0,1)
    rkeys[1] = 1'b1;
    wait_rep_valid();
    check("rep_first_code", 32'(rkif.key_code), 32'd1);
    t_prev = cyc;
    for (int n = 0; n < 3; n++) begin
      wait_rep_valid();
      check("rep_interval", 32'(cyc - t_prev), 32'd32);
      check("rep_code", 32'(rkif.key_code), 32'd1);
      t_prev = cyc;
    end
    check("rep_held", 32'(rkif.key_held), 32'd1);
    rkeys = '0;
    wait_clk(40);
    check("rep_released", 32'(rkif.key_held), 32'd0);

    // 6: (1,0) and (3,0) together, then reset during debounce
    s0 = strobes;
    keys[1*4+0] = 1'b1;
    keys[3*4+0] = 1'b1;
    wait_clk(100);
    check("multi_strobes", 32'(strobes - s0), 32'd1);
    check("multi_code", 32'(last_code), 32'd4);
    keys = '0;
    wait_clk(40);

    wait_col(4'b1110);
    wait_col(4'b1011);
    s0 = strobes;
    keys[2] = 1'b1;
    wait_clk(6);
    check("deb_column_frozen", 32'(kif.column), 32'(4'b1011));
    check("deb_no_strobe_yet", 32'(strobes - s0), 32'd0);
    rst  = 1'b1;
    keys = '0;
    wait_clk(1);
    check("midrst_column", 32'(kif.column), 32'(4'b1110));
    check("midrst_key_valid", 32'(kif.key_valid), 32'd0);
    check("midrst_key_held", 32'(kif.key_held), 32'd0);
    check("midrst_key_code", 32'(kif.key_code), 32'd0);
    rst = 1'b0;
    wait_clk(40);
    check("midrst_no_strobe", 32'(strobes - s0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
